// File: rtl/latch_ctrl_pkg.sv
`default_nettype none
//==============================================================================
// Module      : latch_ctrl_pkg
// Description : Shared types and constants for the latch bank write scheduler.
//               Contains the write-phase state enum and the phase lengths.
//               Each write visits IDLE, then one cycle each of SETUP, OPEN
//               and HOLD.
// Ports       : none (package)
// Revision    : 1.0 - initial release
//==============================================================================
package latch_ctrl_pkg;

   // Write sequencing states. The 2-bit encoding is given explicitly.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      OPEN  = 2'd2,
      HOLD  = 2'd3
   } wr_state_e;

   // Phase lengths in clock cycles. The FSM is built for single-cycle phases.
   localparam int unsigned SETUP_CYCLES = 1;
   localparam int unsigned OPEN_CYCLES  = 1;
   localparam int unsigned HOLD_CYCLES  = 1;

   // Cycles from one accept to the earliest next accept.
   // The extra cycle is the mandatory IDLE visit.
   function automatic int unsigned write_cycles();
      return 1 + SETUP_CYCLES + OPEN_CYCLES + HOLD_CYCLES;
   endfunction

endpackage
`default_nettype wire

// File: rtl/latch_bank_wr_ctrl_rr_arbiter.sv
`default_nettype none
//==============================================================================
// Module      : rr_arbiter
// Description : Round-robin arbiter with a one-hot combinational grant.
//               The search for a requester starts at the rotating pointer and
//               wraps around. On 'advance' the pointer moves to the slot just
//               after the granted requester.
// Ports       : clk      - system clock, rising edge
//               reset_n  - asynchronous active-low reset
//               req      - request vector, one bit per requester
//               advance  - the current grant was taken (handshake done)
//               grant    - one-hot (or zero) grant
// Revision    : 1.0 - initial release
//==============================================================================
module rr_arbiter #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic [N-1:0] req,
   input  logic         advance,
   output logic [N-1:0] grant
);

   localparam int c_PW = (N > 1) ? $clog2(N) : 1;

   logic [c_PW-1:0] r_ptr;
   logic [c_PW-1:0] w_gnt_idx;
   logic [c_PW-1:0] w_ptr_nxt;
   logic [N-1:0]    w_hi_mask;
   logic [N-1:0]    w_hi_req;
   logic [N-1:0]    w_req_sel;

   // The mask covers bits at or above the pointer. If any masked request
   // exists, the lowest one wins. Otherwise the search wraps and the lowest
   // request overall wins.
   assign w_hi_mask = ~((N'(1) << r_ptr) - N'(1));
   assign w_hi_req  = req & w_hi_mask;
   assign w_req_sel = (|w_hi_req) ? w_hi_req : req;
   // Isolate the lowest set bit.
   assign grant     = w_req_sel & (~w_req_sel + N'(1));

   always_comb begin
      w_gnt_idx = '0;
      for (int i = 0; i < N; i++) begin
         if (grant[i]) begin
            w_gnt_idx = c_PW'(i);
         end
      end
   end

   assign w_ptr_nxt = (w_gnt_idx == c_PW'(N - 1)) ? '0 : (w_gnt_idx + c_PW'(1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_ptr <= '0;
      end else if (advance && (|grant)) begin
         r_ptr <= w_ptr_nxt;
      end
   end

endmodule
`default_nettype wire

// File: rtl/latch_bank_wr_ctrl.sv
`default_nettype none
//==============================================================================
// Module      : latch_bank_wr_ctrl
// Description : Write scheduler for a bank of level-sensitive D latches.
//               NUM_REQ requesters share one latch data bus through
//               round-robin arbitration. Each write is sequenced as
//               SETUP / OPEN / HOLD, so lat_d is stable around the gate
//               pulse. All latch-facing outputs come directly from flops.
// Ports       : clk, reset_n          - clock and async active-low reset
//               req_valid/req_ready   - per-requester handshake
//               req_addr/req_data     - packed per-requester address/data
//               lat_d, lat_en         - latch data bus and one-hot gates
//               busy                  - FSM outside IDLE
//               wr_done/_id/wr_err    - completion pulse, source id and
//                                       out-of-range flag
// Revision    : 1.0 - initial release
//==============================================================================
module latch_bank_wr_ctrl
   import latch_ctrl_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int NUM_ENTRIES = 8,
   parameter int DATA_W      = 8,
   parameter int ADDR_W      = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1
) (
   input  logic                                        clk,
   input  logic                                        reset_n,
   input  logic [NUM_REQ-1:0]                          req_valid,
   output logic [NUM_REQ-1:0]                          req_ready,
   input  logic [NUM_REQ*ADDR_W-1:0]                   req_addr,
   input  logic [NUM_REQ*DATA_W-1:0]                   req_data,
   output logic [DATA_W-1:0]                           lat_d,
   output logic [NUM_ENTRIES-1:0]                      lat_en,
   output logic                                        busy,
   output logic                                        wr_done,
   output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] wr_done_id,
   output logic                                        wr_err
);

   localparam int              c_ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [ADDR_W:0] c_NUM_ENT = (ADDR_W + 1)'(NUM_ENTRIES);

   wr_state_e r_state;
   wr_state_e w_state_nxt;

   logic [NUM_REQ-1:0]     w_grant;
   logic                   w_accept;
   logic [c_ID_W-1:0]      w_sel_id;
   logic [ADDR_W-1:0]      w_sel_addr;
   logic [DATA_W-1:0]      w_sel_data;

   logic [ADDR_W-1:0]      r_addr;
   logic [c_ID_W-1:0]      r_id;
   logic [NUM_ENTRIES-1:0] w_addr_dec;
   logic                   w_addr_oor;

   logic [DATA_W-1:0]      r_lat_d,   w_lat_d_nxt;
   logic [NUM_ENTRIES-1:0] r_lat_en,  w_lat_en_nxt;
   logic                   r_busy,    w_busy_nxt;
   logic                   r_done,    w_done_nxt;
   logic [c_ID_W-1:0]      r_done_id, w_done_id_nxt;
   logic                   r_err,     w_err_nxt;

   //---------------------------------------------------------------------------
   // Arbitration and handshake
   //---------------------------------------------------------------------------
   rr_arbiter #(
      .N (NUM_REQ)
   ) u_arb (
      .clk     (clk),
      .reset_n (reset_n),
      .req     (req_valid),
      .advance (w_accept),
      .grant   (w_grant)
   );

   // The grant is a subset of req_valid, so any grant in IDLE is a handshake.
   assign req_ready = (r_state == IDLE) ? w_grant : '0;
   assign w_accept  = (r_state == IDLE) && (|w_grant);

   always_comb begin
      w_sel_id   = '0;
      w_sel_addr = '0;
      w_sel_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_grant[i]) begin
            w_sel_id   = c_ID_W'(i);
            w_sel_addr = req_addr[i*ADDR_W +: ADDR_W];
            w_sel_data = req_data[i*DATA_W +: DATA_W];
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_addr <= '0;
         r_id   <= '0;
      end else if (w_accept) begin
         r_addr <= w_sel_addr;
         r_id   <= w_sel_id;
      end
   end

   //---------------------------------------------------------------------------
   // Address decode of the captured address. It feeds the lat_en flops only.
   //---------------------------------------------------------------------------
   for (genvar e = 0; e < NUM_ENTRIES; e++) begin : g_dec
      assign w_addr_dec[e] = (r_addr == ADDR_W'(e));
   end

   assign w_addr_oor = ({1'b0, r_addr} >= c_NUM_ENT);

   //---------------------------------------------------------------------------
   // FSM: state register
   //---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   //---------------------------------------------------------------------------
   // FSM: next-state logic
   //---------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    w_state_nxt = w_accept ? SETUP : IDLE;
         SETUP:   w_state_nxt = OPEN;
         OPEN:    w_state_nxt = HOLD;
         HOLD:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   //---------------------------------------------------------------------------
   // FSM: output logic. These are the D inputs of the output flops. They are
   // keyed on the next state, so each registered output lines up with its
   // phase and no decode sits after the flops.
   //---------------------------------------------------------------------------
   always_comb begin
      w_lat_d_nxt   = r_lat_d;
      w_lat_en_nxt  = '0;
      w_busy_nxt    = (w_state_nxt != IDLE);
      w_done_nxt    = 1'b0;
      w_done_id_nxt = '0;
      w_err_nxt     = 1'b0;
      case (w_state_nxt)
         // SETUP is entered only from an accept, so the selected data is live.
         SETUP:   w_lat_d_nxt  = w_sel_data;
         // An out-of-range address decodes to all zeros, so the gate stays shut.
         OPEN:    w_lat_en_nxt = w_addr_dec;
         HOLD: begin
            w_done_nxt    = 1'b1;
            w_done_id_nxt = r_id;
            w_err_nxt     = w_addr_oor;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_lat_d   <= '0;
         r_lat_en  <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_done_id <= '0;
         r_err     <= 1'b0;
      end else begin
         r_lat_d   <= w_lat_d_nxt;
         r_lat_en  <= w_lat_en_nxt;
         r_busy    <= w_busy_nxt;
         r_done    <= w_done_nxt;
         r_done_id <= w_done_id_nxt;
         r_err     <= w_err_nxt;
      end
   end

   assign lat_d      = r_lat_d;
   assign lat_en     = r_lat_en;
   assign busy       = r_busy;
   assign wr_done    = r_done;
   assign wr_done_id = r_done_id;
   assign wr_err     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_latch_bank_wr_ctrl.sv
`default_nettype none
//==============================================================================
// Module      : tb_latch_bank_wr_ctrl
// Description : Self-checking bench for latch_bank_wr_ctrl (NUM_ENTRIES=6 so
//               out-of-range addresses exist). A stimulus process predicts
//               each accepted write and queues the expected write. A monitor
//               observes the latch outputs per phase and retires queue
//               entries on wr_done. A latch-bank model records the data each
//               entry ends up holding.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_latch_bank_wr_ctrl;

   localparam int NR = 4;
   localparam int NE = 6;
   localparam int DW = 8;
   localparam int AW = 3;
   localparam int IW = 2;

   logic             clk = 1'b0;
   logic             reset_n = 1'b0;
   logic [NR-1:0]    req_valid = '0;
   logic [NR-1:0]    req_ready;
   logic [NR*AW-1:0] req_addr = '0;
   logic [NR*DW-1:0] req_data = '0;
   logic [DW-1:0]    lat_d;
   logic [NE-1:0]    lat_en;
   logic             busy;
   logic             wr_done;
   logic [IW-1:0]    wr_done_id;
   logic             wr_err;

   latch_bank_wr_ctrl #(
      .NUM_REQ     (NR),
      .NUM_ENTRIES (NE),
      .DATA_W      (DW),
      .ADDR_W      (AW)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_addr   (req_addr),
      .req_data   (req_data),
      .lat_d      (lat_d),
      .lat_en     (lat_en),
      .busy       (busy),
      .wr_done    (wr_done),
      .wr_done_id (wr_done_id),
      .wr_err     (wr_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int id;
      int addr;
      int data;
      int err;
      int en;
      int acc;
   } exp_t;

   exp_t        q[$];
   int          seen[$];
   int          n_tests = 0;
   int          n_fail  = 0;
   int          cyc     = 0;
   int          m_state = 0;   // 0 = idle, 1..3 = cycles into a write
   int          m_ptr   = 0;
   bit          mon_en  = 1'b0;
   logic [DW-1:0] latch_mem [NE];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Call this at a negedge with inputs already driven. It predicts the
   // handshake from the round-robin rule and then advances one clock.
   task automatic step();
      logic [NR-1:0] g;
      int            win;
      int            nxt;
      exp_t          it;
      #1;
      g   = '0;
      win = -1;
      if (m_state == 0) begin
         for (int k = 0; k < NR; k++) begin
            int j;
            j = (m_ptr + k) % NR;
            if (win < 0 && req_valid[j]) win = j;
         end
         if (win >= 0) g[win] = 1'b1;
      end
      chk("req_ready", 32'(req_ready), 32'(g));
      chk("busy", 32'(busy), 32'(m_state != 0));
      for (int i = 0; i < NR; i++) if (req_ready[i]) seen.push_back(i);
      if (win >= 0) begin
         it.id   = win;
         it.addr = int'(req_addr[win*AW +: AW]);
         it.data = int'(req_data[win*DW +: DW]);
         it.err  = (it.addr >= NE) ? 1 : 0;
         it.en   = (it.addr >= NE) ? 0 : (1 << it.addr);
         it.acc  = cyc;
         q.push_back(it);
         m_ptr = (win + 1) % NR;
         nxt   = 1;
      end else begin
         nxt = (m_state == 0) ? 0 : (m_state + 1) % 4;
      end
      @(posedge clk);
      m_state = nxt;
      @(negedge clk);
   endtask

   task automatic do_write(input int id, input int a, input int d);
      req_valid               = NR'(1 << id);
      req_addr[id*AW +: AW]   = AW'(a);
      req_data[id*DW +: DW]   = DW'(d);
      while (m_state != 0) step();
      step();
      req_valid = '0;
   endtask

   // Monitor: classifies each cycle by its position inside a busy run.
   initial begin : mon
      int          ph;
      logic [DW-1:0] held;
      exp_t        cur;
      bit          have;
      ph   = 0;
      held = '0;
      have = 1'b0;
      cur  = '{0, 0, 0, 0, 0, 0};
      forever begin
         @(posedge clk);
         #1;
         if (!mon_en) begin
            ph   = 0;
            held = '0;
         end else begin
            for (int e = 0; e < NE; e++) if (lat_en[e]) latch_mem[e] = lat_d;
            chk("lat_en_onehot0", 32'($countones(lat_en) <= 1), 32'd1);
            ph = busy ? ph + 1 : 0;
            case (ph)
               0: begin
                  chk("idle_lat_en", 32'(lat_en), 32'd0);
                  chk("idle_wr_done", 32'(wr_done), 32'd0);
                  chk("idle_lat_d_kept", 32'(lat_d), 32'(held));
               end
               1: begin
                  have = (q.size() != 0);
                  if (have) cur = q[0];
                  else begin
                     cur = '{0, 0, 0, 0, 0, 0};
                     chk("unexpected_write", 32'd1, 32'd0);
                  end
                  chk("setup_latency", 32'(cyc), 32'(cur.acc + 1));
                  chk("setup_lat_d", 32'(lat_d), 32'(cur.data));
                  chk("setup_lat_en", 32'(lat_en), 32'd0);
                  chk("setup_wr_done", 32'(wr_done), 32'd0);
                  held = lat_d;
               end
               2: begin
                  chk("open_lat_en", 32'(lat_en), 32'(cur.en));
                  chk("open_lat_d", 32'(lat_d), 32'(held));
                  chk("open_wr_done", 32'(wr_done), 32'd0);
               end
               3: begin
                  chk("hold_lat_en", 32'(lat_en), 32'd0);
                  chk("hold_lat_d", 32'(lat_d), 32'(held));
                  chk("hold_wr_done", 32'(wr_done), 32'd1);
                  chk("hold_wr_done_id", 32'(wr_done_id), 32'(cur.id));
                  chk("hold_wr_err", 32'(wr_err), 32'(cur.err));
                  if (have) void'(q.pop_front());
                  have = 1'b0;
               end
               default: chk("busy_too_long", 32'(ph), 32'd3);
            endcase
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      for (int e = 0; e < NE; e++) latch_mem[e] = '0;

      // Reset values
      repeat (3) @(negedge clk);
      #1;
      chk("rst_lat_en", 32'(lat_en), 32'd0);
      chk("rst_lat_d", 32'(lat_d), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_wr_done", 32'(wr_done), 32'd0);
      chk("rst_wr_done_id", 32'(wr_done_id), 32'd0);
      chk("rst_wr_err", 32'(wr_err), 32'd0);
      chk("rst_req_ready", 32'(req_ready), 32'd0);

      // Reset asserted during OPEN drops the write
      @(negedge clk);
      reset_n = 1'b1;
      req_valid = 4'b0010;
      req_addr[1*AW +: AW] = 3'd5;
      req_data[1*DW +: DW] = 8'hA5;
      #1;
      chk("rstopen_ready", 32'(req_ready), 32'b0010);
      @(posedge clk);
      @(negedge clk);
      req_valid = '0;
      @(posedge clk);
      #1;
      chk("rstopen_lat_en", 32'(lat_en), 32'b100000);
      chk("rstopen_lat_d", 32'(lat_d), 32'hA5);
      reset_n = 1'b0;
      #1;
      chk("rstopen_lat_en_clr", 32'(lat_en), 32'd0);
      chk("rstopen_busy_clr", 32'(busy), 32'd0);
      @(posedge clk);
      #1;
      chk("rstopen_no_done", 32'(wr_done), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      m_state = 0;
      m_ptr   = 0;
      q.delete();
      seen.delete();
      mon_en  = 1'b1;

      // Fairness from a freshly reset pointer
      req_valid = 4'hF;
      for (int s = 0; s < 64; s++) begin
         req_addr = 12'($urandom);
         req_data = 32'($urandom);
         step();
      end
      req_valid = '0;
      chk("fair_count", 32'(seen.size()), 32'd16);
      for (int k = 0; k < 16 && k < seen.size(); k++) chk("fair_order", 32'(seen[k]), 32'(k % 4));

      // Directed writes: single, out of range, collision
      do_write(0, 3, 'h3C);
      do_write(1, 7, 'h5A);
      do_write(1, 6, 'h77);
      do_write(2, 1, 'h11);
      do_write(3, 1, 'h22);
      repeat (4) step();
      chk("latch_entry3", 32'(latch_mem[3]), 32'h3C);
      chk("latch_collision", 32'(latch_mem[1]), 32'h22);

      // Randomized traffic
      repeat (400) begin
         req_valid = 4'($urandom_range(0, 15));
         req_addr  = 12'($urandom);
         req_data  = 32'($urandom);
         step();
      end
      req_valid = '0;
      repeat (5) step();
      chk("drain_queue_empty", 32'(q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
